// File: rtl/seq_gen_moore.sv
// Programmable serial pattern generator: captures a pattern, a repeat count and a gap on start.
// It then shifts the pattern out MSB-first with a valid strobe and pulses done after the last bit.
module seq_gen_moore #(
    parameter int SEQ_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEQ_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeats,
    input  logic [CNT_W-1:0] gap,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(SEQ_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SEQ_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [SEQ_W-1:0]   shift_r;
    logic [SEQ_W-1:0]   pat_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [CNT_W-1:0]   rep_cnt_r;
    logic [CNT_W-1:0]   gap_len_r;
    logic [CNT_W-1:0]   gap_cnt_r;
    logic               out_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   rep_init_s;

    // Repeat count of zero still sends the pattern once
    always_comb begin
        rep_init_s = (repeats == '0) ? CNT_W'(1) : repeats;
    end

    // FSM and datapath; outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            pat_r     <= '0;
            bit_cnt_r <= '0;
            rep_cnt_r <= '0;
            gap_len_r <= '0;
            gap_cnt_r <= '0;
            out_r     <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r   <= pattern;
                        pat_r     <= pattern;
                        rep_cnt_r <= rep_init_s;
                        gap_len_r <= gap;
                        bit_cnt_r <= '0;
                        out_r     <= pattern[SEQ_W-1];
                        valid_r   <= 1'b1;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        state_r   <= SHIFT;
                    end else begin
                        out_r   <= 1'b0;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_r != LAST_BIT) begin
                        // out_r mirrors the MSB, so the next bit is one below it
                        shift_r   <= {shift_r[SEQ_W-2:0], 1'b0};
                        out_r     <= shift_r[SEQ_W-2];
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end else if (rep_cnt_r == CNT_W'(1)) begin
                        rep_cnt_r <= '0;
                        shift_r   <= '0;
                        bit_cnt_r <= '0;
                        out_r     <= 1'b0;
                        valid_r   <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else if (gap_len_r == '0) begin
                        rep_cnt_r <= rep_cnt_r - CNT_W'(1);
                        shift_r   <= pat_r;
                        bit_cnt_r <= '0;
                        out_r     <= pat_r[SEQ_W-1];
                    end else begin
                        rep_cnt_r <= rep_cnt_r - CNT_W'(1);
                        gap_cnt_r <= gap_len_r;
                        bit_cnt_r <= '0;
                        out_r     <= 1'b0;
                        valid_r   <= 1'b0;
                        state_r   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == CNT_W'(1)) begin
                        gap_cnt_r <= '0;
                        shift_r   <= pat_r;
                        out_r     <= pat_r[SEQ_W-1];
                        valid_r   <= 1'b1;
                        state_r   <= SHIFT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    out_r   <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    out_r   <= 1'b0;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign out   = out_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule

// File: tb/tb_seq_gen_moore.sv
// Directed bench for seq_gen_moore: stimulus pushes hand-computed per-cycle expectations,
// and a monitor on the falling edge pops and compares {out,valid,busy,done}.
module tb_seq_gen_moore;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeats;
    logic [3:0] gap;
    logic       out;
    logic       valid;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    seq_gen_moore #(.SEQ_W(4), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .repeats (repeats),
        .gap     (gap),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    // Expected {out,valid,busy,done} codes
    localparam logic [3:0] B1 = 4'b1110;
    localparam logic [3:0] B0 = 4'b0110;
    localparam logic [3:0] GP = 4'b0010;
    localparam logic [3:0] DN = 4'b0001;
    localparam logic [3:0] ID = 4'b0000;

    logic [3:0] exp_q[$];
    string      tag_q[$];
    string      tag;
    int         checks = 0;
    int         errors = 0;

    // One clock: drive inputs, let the edge happen, queue what must be visible after it
    task automatic cyc(input logic st, input logic rs, input logic [3:0] e);
        start = st;
        rst   = rs;
        @(posedge clk);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Remaining three bits of a 4-bit pattern after its MSB
    task automatic tail3(input logic [3:0] p);
        for (int i = 2; i >= 0; i--) cyc(1'b0, 1'b0, p[i] ? B1 : B0);
    endtask

    // Monitor: compare the oldest expectation against the outputs each falling edge
    always @(negedge clk) begin
        logic [3:0] e;
        string      t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if ({out, valid, busy, done} !== e) begin
                errors++;
                $display("FAIL %s: {out,valid,busy,done}=%b expected %b at %0t",
                         t, {out, valid, busy, done}, e, $time);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; pattern = 4'b0000; repeats = 4'd0; gap = 4'd0;

        tag = "reset";
        cyc(1'b0, 1'b1, ID);
        cyc(1'b0, 1'b1, ID);
        cyc(1'b0, 1'b0, ID);

        tag = "s1_1010";
        pattern = 4'b1010; repeats = 4'd1; gap = 4'd0;
        cyc(1'b1, 1'b0, B1);
        tail3(4'b1010);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        tag = "s2_1101_x2";
        pattern = 4'b1101; repeats = 4'd2; gap = 4'd0;
        cyc(1'b1, 1'b0, B1);
        tail3(4'b1101);
        cyc(1'b0, 1'b0, B1);
        tail3(4'b1101);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        tag = "s3_gap3";
        pattern = 4'b1010; repeats = 4'd2; gap = 4'd3;
        cyc(1'b1, 1'b0, B1);
        pattern = 4'b0000; repeats = 4'd0; gap = 4'd0;
        tail3(4'b1010);
        cyc(1'b0, 1'b0, GP);
        cyc(1'b0, 1'b0, GP);
        cyc(1'b0, 1'b0, GP);
        cyc(1'b0, 1'b0, B1);
        tail3(4'b1010);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        tag = "s4_rep0";
        pattern = 4'b0110; repeats = 4'd0; gap = 4'd0;
        cyc(1'b1, 1'b0, B0);
        tail3(4'b0110);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        tag = "s4_start_ignored";
        pattern = 4'b1010; repeats = 4'd1; gap = 4'd0;
        cyc(1'b1, 1'b0, B1);
        pattern = 4'b1111;
        cyc(1'b1, 1'b0, B0);
        cyc(1'b0, 1'b0, B1);
        cyc(1'b0, 1'b0, B0);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b1, 1'b0, ID);
        cyc(1'b0, 1'b0, ID);

        tag = "s5_reset_mid";
        pattern = 4'b1100; repeats = 4'd3; gap = 4'd0;
        cyc(1'b1, 1'b0, B1);
        cyc(1'b0, 1'b0, B1);
        cyc(1'b0, 1'b1, ID);
        cyc(1'b0, 1'b0, ID);
        cyc(1'b0, 1'b0, ID);
        cyc(1'b0, 1'b0, ID);
        tag = "s5_after_reset";
        pattern = 4'b1010; repeats = 4'd1; gap = 4'd0;
        cyc(1'b1, 1'b0, B1);
        tail3(4'b1010);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        // Held start: DONE ignores start and returns to IDLE, which accepts it on the next edge
        tag = "s6_start_held";
        pattern = 4'b1001; repeats = 4'd1; gap = 4'd0;
        cyc(1'b1, 1'b0, B1);
        cyc(1'b1, 1'b0, B0);
        cyc(1'b1, 1'b0, B0);
        cyc(1'b1, 1'b0, B1);
        cyc(1'b1, 1'b0, DN);
        cyc(1'b1, 1'b0, ID);
        cyc(1'b1, 1'b0, B1);
        tail3(4'b1001);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        tag = "rep15_max";
        pattern = 4'b1001; repeats = 4'd15; gap = 4'd0;
        cyc(1'b1, 1'b0, B1);
        tail3(4'b1001);
        for (int r = 0; r < 14; r++) begin
            cyc(1'b0, 1'b0, B1);
            tail3(4'b1001);
        end
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        tag = "gap1";
        pattern = 4'b0011; repeats = 4'd2; gap = 4'd1;
        cyc(1'b1, 1'b0, B0);
        tail3(4'b0011);
        cyc(1'b0, 1'b0, GP);
        cyc(1'b0, 1'b0, B0);
        tail3(4'b0011);
        cyc(1'b0, 1'b0, DN);
        cyc(1'b0, 1'b0, ID);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
